// File: rtl/pcs_pkg.sv
// Shared constants and types for the 10GBASE-R TX PCS slice.
//   DATA_WIDTH / HDR_WIDTH : encoder word and sync-header widths
//   SYNC_DATA / SYNC_CTRL  : 64b/66b sync header codes
//   SCR_*                  : self-synchronous scrambler G(x) = 1 + x^39 + x^58
//   FRAME_LEN / PAUSE_*    : upstream throttle schedule (2 idle cycles per 66)
//   BUF_WIDTH              : gearbox bit buffer depth
//   blk_phase_t            : which half of a 66-bit block the next word is
package pcs_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned HDR_WIDTH    = 2;

    localparam logic [1:0]  SYNC_DATA    = 2'b01;
    localparam logic [1:0]  SYNC_CTRL    = 2'b10;

    localparam int unsigned SCR_LEN      = 58;
    localparam int unsigned SCR_TAP_A    = 39;
    localparam int unsigned SCR_TAP_B    = 58;
    localparam logic [SCR_LEN-1:0] SCR_SEED = '1;

    localparam int unsigned FRAME_LEN    = 66;
    localparam int unsigned PAUSE_CYCLES = 2;

    localparam int unsigned BUF_WIDTH    = 128;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } blk_phase_t;

endpackage

// File: rtl/pcs_scrambler.sv
// 32-bit self-synchronous scrambler, G(x) = 1 + x^39 + x^58.
// Bits are processed LSB first; each scrambled bit is fed back into the
// 58-bit state. The state only advances when i_en is high.
// With SCRAMBLE_EN = 0 the data passes through unchanged.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset (state <= SEED)
//   i_en             : advance the state by one 32-bit word this cycle
//   i_data           : payload word to scramble
//   o_data           : combinational scrambled (or bypassed) word
module pcs_scrambler
    import pcs_pkg::*;
#(
    parameter bit                 SCRAMBLE_EN = 1'b1,
    parameter logic [SCR_LEN-1:0] SEED        = SCR_SEED
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [SCR_LEN-1:0]    state;
    logic [SCR_LEN-1:0]    lfsr;
    logic [DATA_WIDTH-1:0] scr_data;

    always_comb begin
        lfsr     = state;
        scr_data = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            scr_data[i] = i_data[i] ^ lfsr[SCR_TAP_A-1] ^ lfsr[SCR_TAP_B-1];
            lfsr        = {lfsr[SCR_LEN-2:0], scr_data[i]};
        end
    end

    assign o_data = SCRAMBLE_EN ? scr_data : i_data;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= SEED;
        end else if (i_en) begin
            state <= lfsr;
        end
    end

endmodule

// File: rtl/pcs_tx_scramble_gearbox.sv
// TX PCS stage after the 64b/66b encoder: scrambles the payload and packs
// 66-bit blocks (header + 64 payload bits) into a continuous 32-bit stream.
// A free-running 66-cycle frame counter raises o_pause for 2 cycles so the
// upstream supplies exactly 64 words per 66 output words.
// Ports:
//   i_clk, i_reset_n     : clock, asynchronous active-low reset
//   i_encoded_data_valid : encoded word present
//   i_encoded_data       : payload half-block (low half first)
//   i_sync_hdr           : sync header, used with the first word of a block
//   i_encoding_err       : encoder error, delayed to match the data path
//   o_pause              : upstream must hold off while high
//   o_tx_data/o_tx_valid : gearboxed stream, bit 0 transmitted first
//   o_encoding_err       : delayed i_encoding_err
//   o_gearbox_err        : pulse on input during pause or buffer overflow
module pcs_tx_scramble_gearbox #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned HDR_WIDTH   = 2,
    parameter bit          SCRAMBLE_EN = 1'b1,
    parameter logic [57:0] SCR_SEED    = {58{1'b1}}
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_encoded_data_valid,
    input  logic [DATA_WIDTH-1:0] i_encoded_data,
    input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
    input  logic                  i_encoding_err,
    output logic                  o_pause,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_encoding_err,
    output logic                  o_gearbox_err
);
    import pcs_pkg::*;

    localparam int unsigned FIRST_BITS = DATA_WIDTH + HDR_WIDTH;
    // No overflow implies count + in_bits <= BUF_WIDTH + DATA_WIDTH.
    localparam int unsigned CAT_WIDTH  = BUF_WIDTH + DATA_WIDTH;

    // ---------------- pause schedule ----------------
    logic [6:0] frame_cnt;
    logic [6:0] frame_cnt_next;
    logic       pause_next;

    always_comb begin
        frame_cnt_next = (frame_cnt == 7'(FRAME_LEN - 1)) ? '0 : frame_cnt + 7'd1;
        // Registered so o_pause is high exactly while frame_cnt is 64 or 65.
        pause_next     = (frame_cnt_next >= 7'(FRAME_LEN - PAUSE_CYCLES));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_cnt <= '0;
            o_pause   <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_next;
            o_pause   <= pause_next;
        end
    end

    // ---------------- stage 1: accept + scramble ----------------
    logic                  accept;
    logic                  pause_viol;
    blk_phase_t            phase;
    logic [DATA_WIDTH-1:0] scr_data;
    logic                  s1_valid;
    logic                  s1_first;
    logic                  s1_enc_err;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [HDR_WIDTH-1:0]  s1_hdr;

    assign accept     = i_encoded_data_valid & ~o_pause;
    assign pause_viol = i_encoded_data_valid &  o_pause;

    pcs_scrambler #(
        .SCRAMBLE_EN (SCRAMBLE_EN),
        .SEED        (SCR_SEED)
    ) u_scrambler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (accept),
        .i_data    (i_encoded_data),
        .o_data    (scr_data)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase      <= FIRST;
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_enc_err <= 1'b0;
            s1_data    <= '0;
            s1_hdr     <= '0;
        end else begin
            s1_valid   <= accept;
            s1_enc_err <= i_encoding_err;
            if (accept) begin
                s1_data  <= scr_data;
                s1_first <= (phase == FIRST);
                if (phase == FIRST) begin
                    s1_hdr <= i_sync_hdr;
                end
                phase <= (phase == FIRST) ? SECOND : FIRST;
            end
        end
    end

    // ---------------- stage 2: gearbox ----------------
    logic [BUF_WIDTH-1:0] gb_buf;
    logic [BUF_WIDTH-1:0] gb_buf_next;
    logic [7:0]           count;
    logic [7:0]           count_next;
    logic [CAT_WIDTH-1:0] in_vec;
    logic [CAT_WIDTH-1:0] cat;
    logic [8:0]           in_bits;
    logic [8:0]           with_in;
    logic [8:0]           after_drain;
    logic [8:0]           total;
    logic                 ovf;
    logic                 drain;

    always_comb begin
        in_vec  = '0;
        in_bits = '0;
        if (s1_valid) begin
            if (s1_first) begin
                in_vec  = CAT_WIDTH'({s1_data, s1_hdr});
                in_bits = 9'(FIRST_BITS);
            end else begin
                in_vec  = CAT_WIDTH'(s1_data);
                in_bits = 9'(DATA_WIDTH);
            end
        end

        // Overflow is judged on the net fill after this cycle's drain; an
        // overflowing word is discarded and the buffer just drains.
        with_in     = {1'b0, count} + in_bits;
        after_drain = (with_in >= 9'(DATA_WIDTH)) ? with_in - 9'(DATA_WIDTH) : with_in;
        ovf         = s1_valid && (after_drain > 9'(BUF_WIDTH));
        if (ovf) begin
            in_vec  = '0;
            in_bits = '0;
        end

        total = {1'b0, count} + in_bits;
        drain = (total >= 9'(DATA_WIDTH));
        cat   = CAT_WIDTH'(gb_buf) | (in_vec << count);

        if (drain) begin
            gb_buf_next = cat[DATA_WIDTH +: BUF_WIDTH];
            count_next  = 8'(total - 9'(DATA_WIDTH));
        end else begin
            gb_buf_next = cat[BUF_WIDTH-1:0];
            count_next  = total[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            gb_buf         <= '0;
            count          <= '0;
            o_tx_data      <= '0;
            o_tx_valid     <= 1'b0;
            o_encoding_err <= 1'b0;
            o_gearbox_err  <= 1'b0;
        end else begin
            gb_buf         <= gb_buf_next;
            count          <= count_next;
            o_tx_valid     <= drain;
            if (drain) begin
                o_tx_data <= cat[DATA_WIDTH-1:0];
            end
            o_encoding_err <= s1_enc_err;
            o_gearbox_err  <= pause_viol | ovf;
        end
    end

endmodule

// File: tb/tb_pcs_tx_scramble_gearbox.sv
// Directed bench for pcs_tx_scramble_gearbox: one scrambling instance and
// one bypass instance, each with its own data inputs. Expected values are
// hand-computed constants plus a bit-serial scrambler / bit-queue model.
module tb_pcs_tx_scramble_gearbox;
    import pcs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        s_valid, b_valid, enc_err;
    logic [31:0] s_data, b_data;
    logic [1:0]  s_hdr, b_hdr;
    logic        s_pause, s_txv, s_encerr, s_gberr;
    logic        b_pause, b_txv, b_encerr, b_gberr;
    logic [31:0] s_txd, b_txd;

    int          errors;
    int          checks;
    int          m_frame;
    logic [57:0] m_scr;
    bit          m_first;
    bit          exp_q[$];
    logic        err_d1, err_d2;
    logic [31:0] r;

    pcs_tx_scramble_gearbox #(.SCRAMBLE_EN(1'b1)) dut_scr (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_encoded_data_valid(s_valid), .i_encoded_data(s_data),
        .i_sync_hdr(s_hdr), .i_encoding_err(enc_err),
        .o_pause(s_pause), .o_tx_data(s_txd), .o_tx_valid(s_txv),
        .o_encoding_err(s_encerr), .o_gearbox_err(s_gberr)
    );

    pcs_tx_scramble_gearbox #(.SCRAMBLE_EN(1'b0)) dut_byp (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_encoded_data_valid(b_valid), .i_encoded_data(b_data),
        .i_sync_hdr(b_hdr), .i_encoding_err(enc_err),
        .o_pause(b_pause), .o_tx_data(b_txd), .o_tx_valid(b_txv),
        .o_encoding_err(b_encerr), .o_gearbox_err(b_gberr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_scr   = '1;
        m_first = 1'b1;
        err_d1  = 1'b0;
        err_d2  = 1'b0;
        m_frame = 0;
    endtask

    // Bit-serial reference for the scrambled stream of dut_scr.
    task automatic push_s(input logic [31:0] d, input logic [1:0] h);
        logic ob;
        if (m_first) begin
            exp_q.push_back(h[0]);
            exp_q.push_back(h[1]);
        end
        for (int i = 0; i < 32; i++) begin
            ob    = d[i] ^ m_scr[38] ^ m_scr[57];
            m_scr = {m_scr[56:0], ob};
            exp_q.push_back(ob);
        end
        m_first = !m_first;
    endtask

    task automatic drive_s(input logic [31:0] d, input logic [1:0] h);
        s_valid = 1'b1;
        s_data  = d;
        s_hdr   = h;
        if (m_frame < 64) push_s(d, h);
    endtask

    task automatic drive_b(input logic [31:0] d, input logic [1:0] h);
        b_valid = 1'b1;
        b_data  = d;
        b_hdr   = h;
    endtask

    // Advance one clock; check per-cycle outputs one time unit after the edge.
    task automatic step();
        logic        vs, vb, e0;
        logic [31:0] w;
        vs = s_valid && (m_frame >= 64);
        vb = b_valid && (m_frame >= 64);
        e0 = enc_err;
        @(posedge clk);
        #1;
        m_frame = (m_frame == 65) ? 0 : m_frame + 1;
        err_d2  = err_d1;
        err_d1  = e0;
        s_valid = 1'b0;
        b_valid = 1'b0;
        enc_err = 1'b0;
        chk("s_pause",   32'(s_pause),  32'(m_frame >= 64));
        chk("b_pause",   32'(b_pause),  32'(m_frame >= 64));
        chk("s_gb_err",  32'(s_gberr),  32'(vs));
        chk("b_gb_err",  32'(b_gberr),  32'(vb));
        chk("s_enc_err", 32'(s_encerr), 32'(err_d2));
        chk("b_enc_err", 32'(b_encerr), 32'(err_d2));
        if (s_txv === 1'b1) begin
            if (exp_q.size() >= 32) begin
                for (int i = 0; i < 32; i++) w[i] = exp_q.pop_front();
                chk("s_stream", s_txd, w);
            end else begin
                chk("s_stream_extra", 32'(exp_q.size()), 32);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_pause"}, 32'(s_pause),  0);
        chk({tag, "_s_txd"},   s_txd,         0);
        chk({tag, "_s_txv"},   32'(s_txv),    0);
        chk({tag, "_s_enc"},   32'(s_encerr), 0);
        chk({tag, "_s_gb"},    32'(s_gberr),  0);
        chk({tag, "_b_pause"}, 32'(b_pause),  0);
        chk({tag, "_b_txd"},   b_txd,         0);
        chk({tag, "_b_txv"},   32'(b_txv),    0);
        chk({tag, "_b_enc"},   32'(b_encerr), 0);
        chk({tag, "_b_gb"},    32'(b_gberr),  0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        s_valid = 1'b0; s_data = '0; s_hdr = '0;
        b_valid = 1'b0; b_data = '0; b_hdr = '0;
        enc_err = 1'b0;
        reset_model();

        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        release_reset();

        // Bypass: hdr 10 + payload 1 -> first word 6. Scrambled: hdr 01 + zeros.
        drive_s(32'h0, SYNC_DATA);
        drive_b(32'h1, SYNC_CTRL);
        enc_err = 1'b1;
        step();                                         // N+1
        chk("b_n1_valid", 32'(b_txv), 0);
        drive_s(32'h0, SYNC_DATA);
        drive_b(32'h0, SYNC_CTRL);
        step();                                         // N+2
        chk("b_first_word",  b_txd, 32'h0000_0006);
        chk("b_first_valid", 32'(b_txv), 1);
        chk("s_first_word",  s_txd, 32'h0000_0001);
        step();                                         // N+3
        chk("b_second_word", b_txd, 32'h0000_0000);
        chk("s_second_word", s_txd, 32'h0FFF_FE00);
        chk("s_second_valid", 32'(s_txv), 1);

        // Idle: 66-bit block leaves 2 bits pending, no more output.
        step();
        chk("s_idle_valid", 32'(s_txv), 0);
        chk("b_idle_valid", 32'(b_txv), 0);
        step();
        step();
        chk("s_idle_hold", s_txd, 32'h0FFF_FE00);
        chk("b_idle_hold", b_txd, 32'h0000_0000);
        chk("s_count_2",   32'(dut_scr.count), 2);
        chk("b_count_2",   32'(dut_byp.count), 2);

        // Next block lands at bit offset 2.
        r = $urandom;
        drive_s(r, SYNC_CTRL);
        drive_b(32'hFFFF_FFFF, SYNC_CTRL);
        step();
        r = $urandom;
        drive_s(r, SYNC_DATA);
        drive_b(32'h0, SYNC_DATA);
        step();
        chk("b_resume_w0", b_txd, 32'hFFFF_FFF8);
        chk("b_resume_v0", 32'(b_txv), 1);
        step();
        chk("b_resume_w1", b_txd, 32'h0000_000F);
        step();
        chk("b_resume_idle", 32'(b_txv), 0);
        chk("b_count_4",     32'(dut_byp.count), 4);

        // Reset in the middle of a block while o_pause is high.
        while (m_frame != 63) step();
        r = $urandom;
        drive_s(r, SYNC_DATA);
        drive_b(r, SYNC_DATA);
        step();
        chk("pre_rst_b_data", b_txd, 32'h0000_000F);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_held");
        release_reset();

        // Continuous input obeying the pause schedule, with two violations.
        for (int k = 0; k < 660; k++) begin
            if (m_frame < 64) begin
                r = $urandom;
                drive_s(r, ($urandom % 2 == 0) ? SYNC_DATA : SYNC_CTRL);
            end else if (k == 130) begin
                s_valid = 1'b1;
                s_data  = $urandom;
                s_hdr   = SYNC_CTRL;
            end else if (k == 131) begin
                b_valid = 1'b1;
                b_data  = $urandom;
                b_hdr   = SYNC_DATA;
            end
            step();
            if (k >= 1) chk("s_valid_cont", 32'(s_txv), 1);
            chk("s_count_le98", 32'(dut_scr.count <= 8'd98), 1);
        end
        step();
        step();
        chk("s_drained_valid", 32'(s_txv), 0);
        chk("s_queue_empty",   32'(exp_q.size()), 0);
        chk("b_never_valid",   32'(b_txv), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
